// File: rtl/multibyte_add_pkg.sv
// Shared definitions for the byte-serial multi-precision adder:
// limb width, sequencer state encoding and the signed-overflow rule.
package multibyte_add_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Two's-complement overflow: both addends share a sign and the
   // result's sign differs from it.
   function automatic logic signedOverflow(input logic aMsb,
                                           input logic bMsb,
                                           input logic rMsb);
      return (aMsb == bMsb) && (rMsb != aMsb);
   endfunction

endpackage

// File: rtl/multibyte_add_seq_if.sv
// Host-side bundle for the multi-byte add/subtract sequencer.
// The host drives the request and operands; the sequencer returns
// status, a done pulse and held results.
interface multibyte_add_seq_if #(
   parameter int NBYTES = 4
);
   import multibyte_add_pkg::*;

   localparam int W = BYTE_W * NBYTES;

   logic         start;
   logic         sub;
   logic         cin;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   modport master (
      output start, sub, cin, a, b,
      input  busy, done, sum, cout, ovf
   );

   modport slave (
      input  start, sub, cin, a, b,
      output busy, done, sum, cout, ovf
   );

endinterface

// File: rtl/byte_ripple_add.sv
// Combinational 8-bit ripple-carry adder built from full-adder bit slices.
// The sequencer time-multiplexes this single instance across all limbs.
module byte_ripple_add
   import multibyte_add_pkg::*;
(
   input  logic [BYTE_W-1:0] a,
   input  logic [BYTE_W-1:0] b,
   input  logic              cin,
   output logic              cout,
   output logic [BYTE_W-1:0] sum
);

   logic [BYTE_W:0] w_carry;

   assign w_carry[0] = cin;

   // One full adder per bit; carry ripples from bit 0 upward.
   for (genvar i = 0; i < BYTE_W; i++) begin : g_slice
      assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
      assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
   end

   assign cout = w_carry[BYTE_W];

endmodule

// File: rtl/multibyte_add_seq.sv
// Byte-serial NBYTES x 8-bit add/subtract sequencer. Operands are latched
// on accept, one limb per cycle is pushed through a shared 8-bit adder
// (LSB first) with the carry chained in a register, and the full result
// is published together with a one-cycle done pulse.
module multibyte_add_seq
   import multibyte_add_pkg::*;
#(
   parameter int NBYTES = 4
) (
   input  logic                clk,
   input  logic                rst,
   multibyte_add_seq_if.slave  bus
);

   localparam int W    = BYTE_W * NBYTES;
   localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

   state_t            r_state;
   state_t            w_nextState;

   logic [IDXW-1:0]   r_idx;
   logic              r_carry;
   logic [W-1:0]      r_a;
   logic [W-1:0]      r_bEff;
   logic [W-1:0]      r_partial;
   logic [W-1:0]      r_sum;
   logic              r_cout;
   logic              r_ovf;

   logic [BYTE_W-1:0] w_aByte;
   logic [BYTE_W-1:0] w_bByte;
   logic [BYTE_W-1:0] w_sumByte;
   logic              w_byteCout;
   logic [W-1:0]      w_result;
   logic              w_lastByte;
   logic              w_busy;
   logic              w_done;

   assign w_aByte    = r_a[int'(r_idx) * BYTE_W +: BYTE_W];
   assign w_bByte    = r_bEff[int'(r_idx) * BYTE_W +: BYTE_W];
   assign w_lastByte = (r_idx == LAST_IDX);

   byte_ripple_add u_adder (
      .a    (w_aByte),
      .b    (w_bByte),
      .cin  (r_carry),
      .cout (w_byteCout),
      .sum  (w_sumByte)
   );

   // Partial result with the limb currently leaving the adder merged in,
   // so the last RUN edge can publish the complete word directly.
   always_comb begin
      w_result = r_partial;
      w_result[int'(r_idx) * BYTE_W +: BYTE_W] = w_sumByte;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and status decode; start is only looked at in IDLE.
   always_comb begin
      w_nextState = r_state;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_nextState = RUN;
            end
         end
         RUN: begin
            w_busy = 1'b1;
            if (w_lastByte) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            w_busy      = 1'b1;
            w_done      = 1'b1;
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Operand capture on accept and per-limb accumulation while running.
   // Subtraction is folded into addition by inverting B and forcing the
   // initial carry to 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx     <= '0;
         r_carry   <= 1'b0;
         r_a       <= '0;
         r_bEff    <= '0;
         r_partial <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_a     <= bus.a;
                  r_bEff  <= bus.sub ? ~bus.b : bus.b;
                  r_carry <= bus.sub ? 1'b1 : bus.cin;
                  r_idx   <= '0;
               end
            end
            RUN: begin
               r_partial <= w_result;
               r_carry   <= w_byteCout;
               if (w_lastByte) begin
                  r_idx <= '0;
               end else begin
                  r_idx <= r_idx + IDXW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Published results change only on the edge that enters DONE, so they
   // remain stable between done pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sum  <= '0;
         r_cout <= 1'b0;
         r_ovf  <= 1'b0;
      end else if (r_state == RUN && w_lastByte) begin
         r_sum  <= w_result;
         r_cout <= w_byteCout;
         r_ovf  <= signedOverflow(r_a[W-1], r_bEff[W-1], w_result[W-1]);
      end
   end

   assign bus.busy = w_busy;
   assign bus.done = w_done;
   assign bus.sum  = r_sum;
   assign bus.cout = r_cout;
   assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Directed bench for the byte-serial add/subtract sequencer. Expected
// results come from a full-width reference computation and are queued
// when an operation is issued, then popped when done is observed.
module tb_multibyte_add_seq;

   localparam int NBYTES = 4;
   localparam int W      = 8 * NBYTES;
   localparam int PERIOD = NBYTES + 2;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   multibyte_add_seq_if #(.NBYTES(NBYTES)) bus ();

   multibyte_add_seq #(.NBYTES(NBYTES)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   exp_t         sb[$];
   int           nVectors     = 0;
   int           nMiscompares = 0;
   logic [W-1:0] lastSum      = '0;
   logic         lastCout     = 1'b0;
   logic         lastOvf      = 1'b0;

   // Full-width reference: unsigned add modulo 2^W with carry out.
   function automatic exp_t refModel(input bit s, input bit c,
                                     input logic [W-1:0] x,
                                     input logic [W-1:0] y);
      exp_t         r;
      logic [W-1:0] be;
      logic [W:0]   t;
      be     = s ? ~y : y;
      t      = {1'b0, x} + {1'b0, be} + {{W{1'b0}}, (s ? 1'b1 : c)};
      r.sum  = t[W-1:0];
      r.cout = t[W];
      r.ovf  = (x[W-1] == be[W-1]) && (t[W-1] != x[W-1]);
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs,
                              input logic [63:0] exp);
      nVectors++;
      assert (obs === exp) else begin
         nMiscompares++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
         $error("[TB] check %s miscompared", tag);
      end
   endtask

   task automatic checkHeld(input string tag);
      checkOutput({tag, " sum held"},  bus.sum,  lastSum);
      checkOutput({tag, " cout held"}, bus.cout, lastCout);
      checkOutput({tag, " ovf held"},  bus.ovf,  lastOvf);
   endtask

   task automatic popAndCompare(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         checkOutput({tag, " scoreboard empty"}, 64'd0, 64'd1);
      end else begin
         e = sb.pop_front();
         checkOutput({tag, " sum"},  bus.sum,  e.sum);
         checkOutput({tag, " cout"}, bus.cout, e.cout);
         checkOutput({tag, " ovf"},  bus.ovf,  e.ovf);
         lastSum  = e.sum;
         lastCout = e.cout;
         lastOvf  = e.ovf;
      end
   endtask

   // Issue one op from IDLE (called at a falling edge), scramble the
   // operand inputs while it runs, and track busy/done cycle by cycle.
   task automatic applyStimulus(input string tag, input bit s, input bit c,
                                input logic [W-1:0] x, input logic [W-1:0] y);
      bus.sub   = s;
      bus.cin   = c;
      bus.a     = x;
      bus.b     = y;
      bus.start = 1'b1;
      sb.push_back(refModel(s, c, x, y));
      @(negedge clk);
      bus.start = 1'b0;
      for (int k = 0; k <= NBYTES; k++) begin
         if (k > 0) @(negedge clk);
         bus.a   = $urandom;
         bus.b   = $urandom;
         bus.sub = 1'($urandom);
         bus.cin = 1'($urandom);
         checkOutput({tag, " busy"}, bus.busy, 1'b1);
         checkOutput({tag, " done"}, bus.done, (k == NBYTES));
         if (k == NBYTES) popAndCompare(tag);
         else if (k == 0) checkHeld(tag);
      end
      @(negedge clk);
      checkOutput({tag, " idle busy"}, bus.busy, 1'b0);
      checkOutput({tag, " idle done"}, bus.done, 1'b0);
      checkHeld({tag, " after"});
   endtask

   // Safety net so the run always ends even if the clock stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.sub   = 1'b0;
      bus.cin   = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      #2;
      checkOutput("reset busy", bus.busy, 1'b0);
      checkOutput("reset done", bus.done, 1'b0);
      checkHeld("reset");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      applyStimulus("add small",   1'b0, 1'b0, 32'h0000000A, 32'h00000005);
      applyStimulus("carry chain", 1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001);
      applyStimulus("all ones",    1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
      applyStimulus("overflow",    1'b0, 1'b0, 32'h7FFFFFFF, 32'h00000001);
      applyStimulus("sub borrow",  1'b1, 1'b1, 32'h00000005, 32'h0000000A);
      applyStimulus("sub ovf",     1'b1, 1'b0, 32'h80000000, 32'h00000001);
      applyStimulus("mid carry",   1'b0, 1'b1, 32'h00FF00FF, 32'h00010001);
      applyStimulus("sub equal",   1'b1, 1'b0, 32'h12345678, 32'h12345678);
      applyStimulus("neg ovf",     1'b0, 1'b0, 32'h80000000, 32'h80000000);

      // Start held high with operands changing every cycle: only the
      // operands present at each IDLE edge may be used.
      bus.start = 1'b1;
      for (int n = 0; n < 3 * PERIOD; n++) begin
         int ph;
         if (n > 0) @(negedge clk);
         ph = n % PERIOD;
         checkOutput("stream busy", bus.busy, (ph != 0));
         checkOutput("stream done", bus.done, (ph == PERIOD - 1));
         if (ph == PERIOD - 1) popAndCompare("stream");
         bus.a   = $urandom;
         bus.b   = $urandom;
         bus.sub = 1'($urandom);
         bus.cin = 1'($urandom);
         if (ph == 0) sb.push_back(refModel(bus.sub, bus.cin, bus.a, bus.b));
      end
      @(negedge clk);
      bus.start = 1'b0;
      checkOutput("stream end busy", bus.busy, 1'b0);
      checkOutput("stream end done", bus.done, 1'b0);

      // Asynchronous reset two cycles into RUN, with a nonzero result held.
      applyStimulus("pre reset", 1'b0, 1'b0, 32'h11111111, 32'h22222222);
      bus.a     = 32'hDEADBEEF;
      bus.b     = 32'h01020304;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      lastSum  = '0;
      lastCout = 1'b0;
      lastOvf  = 1'b0;
      checkOutput("abort busy", bus.busy, 1'b0);
      checkOutput("abort done", bus.done, 1'b0);
      checkHeld("abort");
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < PERIOD + 1; n++) begin
         @(negedge clk);
         checkOutput("post abort done", bus.done, 1'b0);
         checkOutput("post abort busy", bus.busy, 1'b0);
      end
      applyStimulus("after reset", 1'b0, 1'b1, 32'h0000FFFF, 32'h00000000);

      checkOutput("scoreboard drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
